// File: rtl/bch_pkg.sv
// Shared BCH encoder/decoder definitions: size limits, FSM encoding and
// configuration helpers used by both the encoder and the decode chain.
package bch_pkg;

  localparam int N_MAX = 1023;
  localparam int T_MAX = 4;
  localparam int M_MAX = 10;
  localparam int R_MAX = T_MAX * M_MAX;
  localparam int CNT_W = $clog2(N_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Parity length r = m*t; only meaningful once the config has passed cfg_valid
  function automatic logic [5:0] r_of(input logic [3:0] m, input logic [2:0] t);
    logic [6:0] prod;
    prod = {3'd0, m} * {4'd0, t};
    return prod[5:0];
  endfunction

  function automatic logic cfg_valid(input logic [CNT_W-1:0] n,
                                     input logic [3:0]       m,
                                     input logic [2:0]       t);
    logic [15:0] n_lim;
    n_lim = (16'd1 << m) - 16'd1;
    return (m >= 4'd2) && (m <= 4'(M_MAX)) &&
           (t != 3'd0) && (t <= 3'(T_MAX)) &&
           ({4'd0, r_of(m, t)} < n) &&
           ({6'd0, n} <= n_lim);
  endfunction

endpackage

// File: rtl/bch_encoder_if.sv
// Configuration, message-in and codeword-out handshake bundle of the BCH encoder.
interface bch_encoder_if;
  import bch_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  n;
  logic [3:0]        m;
  logic [2:0]        t;
  logic [R_MAX-1:0]  gen_poly;
  logic              din;
  logic              din_valid;
  logic              din_ready;
  logic              dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport master (
    output start, n, m, t, gen_poly, din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_last, busy, done, cfg_err
  );

  modport slave (
    input  start, n, m, t, gen_poly, din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_last, busy, done, cfg_err
  );

endinterface

// File: rtl/bch_lfsr.sv
// Variable-length Galois LFSR over GF(2): active length r, taps from g.
// With feedback it divides the input stream by g(x); without it, it shifts out.
module bch_lfsr
  import bch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [5:0]       r,
  input  logic [R_MAX-1:0] g,
  input  logic             shift_en,
  input  logic             fb_en,
  input  logic             bit_in,
  output logic             msb
);

  logic [R_MAX-1:0] lfsr_r;
  logic [R_MAX-1:0] mask_s;
  logic             fb_s;

  // Active-length mask and the tap at bit r-1, both selected by r
  always_comb begin
    mask_s = {R_MAX{1'b0}};
    msb    = 1'b0;
    for (int i = 0; i < R_MAX; i++) begin
      mask_s[i] = (6'(i) < r);
      msb       = msb | (lfsr_r[i] & (6'(i + 1) == r));
    end
  end

  assign fb_s = fb_en & (bit_in ^ msb);

  // Shift register with optional generator feedback
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= {R_MAX{1'b0}};
    end else if (clr) begin
      lfsr_r <= {R_MAX{1'b0}};
    end else if (shift_en) begin
      lfsr_r <= ((lfsr_r << 1) ^ (fb_s ? g : {R_MAX{1'b0}})) & mask_s;
    end
  end

endmodule

// File: rtl/bch_encoder.sv
// Systematic BCH encoder: passes k message bits through, then appends the
// r = m*t parity bits of u(x)*x^r mod g(x), highest degree first.
module bch_encoder
  import bch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  bch_encoder_if.slave bus
);

  state_e           state_r;
  state_e           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] k_last_r;
  logic [5:0]       r_r;
  logic             err_r;

  logic [5:0]       r_in_s;
  logic             cfg_ok_s;
  logic             start_ok_s;
  logic             xfer_s;
  logic             msg_end_s;
  logic             par_end_s;
  logic             lfsr_msb_s;

  assign r_in_s     = r_of(bus.m, bus.t);
  assign cfg_ok_s   = cfg_valid(bus.n, bus.m, bus.t);
  // The done cycle also accepts a start so codewords can run back to back
  assign start_ok_s = bus.start && ((state_r == IDLE) || (state_r == FIN));
  assign msg_end_s  = (cnt_r == k_last_r);
  assign par_end_s  = (cnt_r == ({4'd0, r_r} - 10'd1));

  // Bit transfer qualifier for the current phase
  always_comb begin
    case (state_r)
      MSG:     xfer_s = bus.din_valid && bus.dout_ready;
      PAR:     xfer_s = bus.dout_ready;
      default: xfer_s = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE, FIN: begin
        if (start_ok_s) begin
          state_nx_s = cfg_ok_s ? MSG : FIN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MSG: begin
        if (xfer_s && msg_end_s) begin
          state_nx_s = PAR;
        end else begin
          state_nx_s = MSG;
        end
      end
      PAR: begin
        if (xfer_s && par_end_s) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = PAR;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Latched configuration and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      k_last_r <= {CNT_W{1'b0}};
      r_r      <= 6'd0;
      err_r    <= 1'b0;
    end else if (start_ok_s) begin
      cnt_r    <= {CNT_W{1'b0}};
      r_r      <= r_in_s;
      k_last_r <= bus.n - {4'd0, r_in_s} - 10'd1;
      err_r    <= ~cfg_ok_s;
    end else if (xfer_s) begin
      if ((state_r == MSG) && msg_end_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + 10'd1;
      end
    end
  end

  bch_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok_s),
    .r        (r_r),
    .g        (bus.gen_poly),
    .shift_en (xfer_s),
    .fb_en    (state_r == MSG),
    .bit_in   (bus.din),
    .msb      (lfsr_msb_s)
  );

  // FSM outputs and handshake muxing
  always_comb begin
    bus.dout       = 1'b0;
    bus.dout_valid = 1'b0;
    bus.din_ready  = 1'b0;
    bus.dout_last  = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.cfg_err    = 1'b0;
    case (state_r)
      MSG: begin
        bus.dout       = bus.din;
        bus.dout_valid = bus.din_valid;
        bus.din_ready  = bus.dout_ready;
        bus.busy       = 1'b1;
      end
      PAR: begin
        bus.dout       = lfsr_msb_s;
        bus.dout_valid = 1'b1;
        bus.dout_last  = par_end_s;
        bus.busy       = 1'b1;
      end
      FIN: begin
        bus.done    = 1'b1;
        bus.cfg_err = err_r;
      end
      default: begin
        bus.done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bch_encoder.sv
// Bench for bch_encoder: random handshake gaps, codewords checked against a
// polynomial long-division model of u(x)*x^r mod g(x).
`timescale 1ns/1ps
module tb_bch_encoder;
  import bch_pkg::*;

  typedef bit bitq_t[$];
  typedef struct {
    bit b;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bch_encoder_if bus();
  bch_encoder dut (.clk(clk), .rst(rst), .bus(bus));

  int    n_cmp = 0;
  int    n_bad = 0;
  int    ready_pct = 100;
  int    valid_pct = 100;
  exp_t  exp_q[$];
  bit    src_q[$];
  bit    in_xfer = 1'b0;
  bit    flush_src = 1'b0;
  int    msg_xfers = 0;
  bit    saw_din_ready = 1'b0;
  bit    stall_pending = 1'b0;
  bit    stall_dout = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cfg_ok(int n, int m, int t);
    return (m >= 2) && (m <= 10) && (t >= 1) && (t <= 4) && (m * t < n) && (n <= (1 << m) - 1);
  endfunction

  // Codeword = message then remainder of u(x)*x^r / g(x), highest degree first
  function automatic bitq_t encode(int n, int r, logic [R_MAX-1:0] g, bitq_t msg);
    bit    d[];
    bitq_t cw;
    d = new[n];
    foreach (msg[j]) d[n - 1 - j] = msg[j];
    for (int deg = n - 1; deg >= r; deg--) begin
      if (d[deg]) begin
        for (int i = 0; i <= r; i++) d[deg - r + i] ^= ((i == r) ? 1'b1 : g[i]);
      end
    end
    cw = msg;
    for (int i = r - 1; i >= 0; i--) cw.push_back(d[i]);
    return cw;
  endfunction

  function automatic bitq_t bits_of(logic [63:0] v, int len);
    bitq_t q;
    for (int i = len - 1; i >= 0; i--) q.push_back(v[i]);
    return q;
  endfunction

  function automatic logic [63:0] pack(bitq_t q);
    logic [63:0] v = 64'd0;
    foreach (q[i]) v = {v[62:0], q[i]};
    return v;
  endfunction

  function automatic bitq_t rand_msg(int len);
    bitq_t q;
    for (int i = 0; i < len; i++) q.push_back(1'($urandom_range(0, 1)));
    return q;
  endfunction

  // Message source: holds din/din_valid until accepted
  initial begin
    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (flush_src) begin
        src_q.delete();
        bus.din_valid = 1'b0;
        flush_src = 1'b0;
      end else begin
        if (in_xfer) begin
          if (src_q.size() > 0) void'(src_q.pop_front());
          bus.din_valid = 1'b0;
        end
        if (!bus.din_valid && src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
          bus.din = src_q[0];
          bus.din_valid = 1'b1;
        end
      end
    end
  end

  // Codeword sink with random backpressure
  initial begin
    bus.dout_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.dout_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Compare process: every accepted codeword bit against the model queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      in_xfer = bus.din_valid && bus.din_ready;
      if (in_xfer) msg_xfers++;
      if (bus.din_ready) saw_din_ready = 1'b1;
      if (rst) begin
        stall_pending = 1'b0;
      end else begin
        if (stall_pending) begin
          check("stall_valid", bus.dout_valid, 1'b1);
          check("stall_data", bus.dout, stall_dout);
        end
        if (bus.dout_valid && bus.dout_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_bit: got dout=%0b with no bit expected at %0t", bus.dout, $time);
          end else begin
            e = exp_q.pop_front();
            check("dout", bus.dout, e.b);
            check("dout_last", bus.dout_last, e.last);
          end
        end
        stall_pending = bus.dout_valid && !bus.dout_ready;
        stall_dout = bus.dout;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic launch(int n, int m, int t, logic [R_MAX-1:0] g, bitq_t msg);
    bitq_t cw;
    exp_t  e;
    bus.n = 10'(n);
    bus.m = 4'(m);
    bus.t = 3'(t);
    bus.gen_poly = g;
    msg_xfers = 0;
    saw_din_ready = 1'b0;
    if (cfg_ok(n, m, t)) begin
      cw = encode(n, m * t, g, msg);
      foreach (cw[i]) begin
        e.b = cw[i];
        e.last = (i == cw.size() - 1);
        exp_q.push_back(e);
      end
      foreach (msg[i]) src_q.push_back(msg[i]);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; optionally pulses start again mid-codeword
  task automatic finish_cw(string name, bit exp_err, int poke_at);
    int cyc = 0;
    bit poked = 1'b0;
    while (!bus.done && cyc < 20000) begin
      if (poke_at >= 0 && !poked && msg_xfers >= poke_at) begin
        bus.start = 1'b1;
        poked = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, cyc);
      exp_q.delete();
      flush_src = 1'b1;
    end else begin
      check({name, "_cfg_err"}, bus.cfg_err, exp_err);
      check({name, "_busy"}, bus.busy, 1'b0);
      check({name, "_left"}, exp_q.size(), 0);
      if (exp_err) begin
        check({name, "_latency"}, cyc, 0);
        check({name, "_din_ready"}, saw_din_ready, 1'b0);
      end
    end
  endtask

  initial begin
    bitq_t            none;
    int               m, t, r, lim, n;
    logic [63:0]      rnd;
    logic [R_MAX-1:0] g;
    int               bad_cfg [6][3] = '{'{8, 3, 1}, '{12, 4, 3}, '{100, 11, 1},
                                        '{100, 4, 0}, '{3, 1, 1}, '{100, 5, 5}};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.n = 10'd0;
    bus.m = 4'd0;
    bus.t = 3'd0;
    bus.gen_poly = {R_MAX{1'b0}};
    repeat (3) tick();
    check("reset_outputs", {bus.dout, bus.dout_valid, bus.din_ready, bus.dout_last,
                            bus.busy, bus.done, bus.cfg_err}, 7'b0);
    rst = 1'b0;
    tick();

    check("model_c1", pack(encode(7, 3, 40'h3, bits_of(64'h8, 4))), 64'h45);
    check("model_c2", pack(encode(15, 8, 40'hD1, bits_of(64'h1, 7))), 64'h1D1);
    check("model_c2z", pack(encode(15, 8, 40'hD1, bits_of(64'h0, 7))), 64'h0);

    launch(7, 3, 1, 40'h3, bits_of(64'h8, 4));
    finish_cw("c1", 1'b0, -1);
    launch(15, 4, 2, 40'hD1, bits_of(64'h1, 7));
    finish_cw("c2", 1'b0, -1);
    launch(15, 4, 2, 40'hD1, bits_of(64'h0, 7));
    finish_cw("c2z", 1'b0, -1);

    ready_pct = 50;
    valid_pct = 50;
    for (int i = 0; i < 6; i++) begin
      launch(15, 4, 2, 40'hD1, (i == 0) ? bits_of(64'h1, 7) : rand_msg(7));
      finish_cw("c3", 1'b0, -1);
    end

    ready_pct = 100;
    valid_pct = 100;
    for (int i = 0; i < 6; i++) begin
      launch(bad_cfg[i][0], bad_cfg[i][1], bad_cfg[i][2], 40'h3, none);
      finish_cw("c4", 1'b1, -1);
    end

    tick();
    launch(15, 4, 2, 40'hD1, bits_of(64'h5B, 7));
    for (int cyc = 0; cyc < 100 && msg_xfers < 3; cyc++) tick();
    rst = 1'b1;
    flush_src = 1'b1;
    exp_q.delete();
    tick();
    check("rst_outputs", {bus.dout, bus.dout_valid, bus.din_ready, bus.dout_last,
                          bus.busy, bus.done, bus.cfg_err}, 7'b0);
    rst = 1'b0;
    tick();
    launch(7, 3, 1, 40'h3, bits_of(64'h8, 4));
    finish_cw("c5", 1'b0, -1);

    ready_pct = 70;
    valid_pct = 70;
    launch(15, 4, 2, 40'hD1, rand_msg(7));
    finish_cw("c6_poke", 1'b0, 3);
    launch(7, 3, 1, 40'h3, rand_msg(4));
    finish_cw("c6_b2b", 1'b0, 2);

    ready_pct = 80;
    valid_pct = 80;
    for (int i = 0; i < 20; i++) begin
      m = $urandom_range(3, 10);
      lim = (1 << m) - 1;
      t = $urandom_range(1, 4);
      while (m * t >= lim) t--;
      r = m * t;
      n = $urandom_range(r + 1, (lim < 200) ? lim : 200);
      rnd = {$urandom(), $urandom()};
      launch(n, m, t, rnd[R_MAX-1:0], rand_msg(n - r));
      finish_cw("rand_cfg", 1'b0, -1);
    end

    ready_pct = 90;
    valid_pct = 90;
    for (int i = 0; i < 24; i++) begin
      rnd = {$urandom(), $urandom()};
      g = rnd[R_MAX-1:0] | 40'h1;
      launch(1023, 10, 4, g, rand_msg(1023 - 40));
      finish_cw("big", 1'b0, -1);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
